// File: rtl/dma_channel_sched_if.sv
// Handshake bundle between dma_channel_sched, its request sources and the DMA engine.
// The master modport is the scheduler side; the slave modport is the sources/engine side.
interface dma_channel_sched_if #(
    parameter int NCH   = 4,
    parameter int LEN_W = 16,
    parameter int BURST = 8
);
    localparam int CH_W    = $clog2(NCH);
    localparam int WORDS_W = $clog2(BURST) + 1;

    logic [NCH-1:0]       ch_req;
    logic [NCH*LEN_W-1:0] ch_len;
    logic [NCH-1:0]       ch_grant;
    logic [NCH-1:0]       ch_done;
    logic                 dma_start;
    logic [CH_W-1:0]      dma_ch;
    logic [WORDS_W-1:0]   dma_words;
    logic                 dma_abort;
    logic                 dma_word_ack;

    modport master (
        input  ch_req, ch_len, dma_word_ack,
        output ch_grant, ch_done, dma_start, dma_ch, dma_words, dma_abort
    );

    modport slave (
        output ch_req, ch_len, dma_word_ack,
        input  ch_grant, ch_done, dma_start, dma_ch, dma_words, dma_abort
    );
endinterface

// File: rtl/dma_channel_sched.sv
// Round-robin slice scheduler time-sharing one DMA engine between NCH channels.
// Build macro DMA_SCHED_PRIO_EN: channel 0 wins every arbitration it requests in.
module dma_channel_sched #(
    parameter int NCH   = 4,
    parameter int LEN_W = 16,
    parameter int BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    dma_channel_sched_if.master bus
);
    localparam int CH_W    = $clog2(NCH);
    localparam int WORDS_W = $clog2(BURST) + 1;
    localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(NCH - 1);
    localparam logic [WORDS_W-1:0] BURST_WDS = WORDS_W'(BURST);
    localparam logic [LEN_W-1:0]   BURST_LEN = LEN_W'(BURST);
    localparam logic [NCH-1:0]     ONE_HOT0  = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        ISSUE  = 3'd2,
        RUN    = 3'd3,
        RETIRE = 3'd4
    } state_t;

    state_t             state_r;
    logic [CH_W-1:0]    last_grant_r;
    logic [CH_W-1:0]    cur_ch_r;
    logic [LEN_W-1:0]   remaining_r [NCH];
    logic [NCH-1:0]     active_r;
    logic [WORDS_W-1:0] ack_cnt_r;

    logic [NCH-1:0]     ch_grant_r;
    logic [NCH-1:0]     ch_done_r;
    logic               dma_start_r;
    logic [CH_W-1:0]    dma_ch_r;
    logic [WORDS_W-1:0] dma_words_r;
    logic               dma_abort_r;

    logic [CH_W:0]      arb_s;
    logic               pick_vld_s;
    logic [CH_W-1:0]    pick_s;
    logic [LEN_W-1:0]   pick_len_s;
    logic [WORDS_W-1:0] pick_words_s;
    logic [LEN_W-1:0]   rem_after_s;
    logic               slice_end_s;
    logic               abort_s;
    logic               arb_go_s;

    // Walk from last+NCH down to last+1 so the channel nearest after last wins; MSB flags a hit.
    function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] req, input logic [CH_W-1:0] last);
        logic [CH_W:0]   res;
        logic [CH_W-1:0] ci;
        int              idx;
        res = {(CH_W+1){1'b0}};
        for (int k = NCH; k >= 1; k--) begin
            idx = int'(last) + k;
            idx = (idx >= NCH) ? idx - NCH : idx;
            ci  = CH_W'(idx);
            res = req[ci] ? {1'b1, ci} : res;
        end
        return res;
    endfunction

`ifdef DMA_SCHED_PRIO_EN
    assign arb_s = bus.ch_req[0] ? {1'b1, {CH_W{1'b0}}} : rr_pick(bus.ch_req, last_grant_r);
`else
    assign arb_s = rr_pick(bus.ch_req, last_grant_r);
`endif
    assign pick_vld_s = arb_s[CH_W];
    assign pick_s     = arb_s[CH_W-1:0];

    // Slice size for the winner: live remainder if mid-transfer, otherwise a fresh ch_len sample.
    always_comb begin
        if (active_r[pick_s]) begin
            pick_len_s = remaining_r[pick_s];
        end else begin
            pick_len_s = bus.ch_len[int'(pick_s)*LEN_W +: LEN_W];
        end
        if (pick_len_s > BURST_LEN) begin
            pick_words_s = BURST_WDS;
        end else begin
            pick_words_s = WORDS_W'(pick_len_s);
        end
    end

    // Slice completion, abort detection and whether this edge performs an arbitration.
    always_comb begin
        slice_end_s = 1'b0;
        abort_s     = 1'b0;
        arb_go_s    = 1'b0;
        rem_after_s = remaining_r[cur_ch_r] - LEN_W'(dma_words_r);
        case (state_r)
            IDLE: begin
                arb_go_s = pick_vld_s;
            end
            RUN: begin
                slice_end_s = bus.dma_word_ack && ((ack_cnt_r + WORDS_W'(1)) == dma_words_r);
                abort_s     = !slice_end_s && !bus.ch_req[cur_ch_r];
                arb_go_s    = abort_s && pick_vld_s;
            end
            RETIRE: begin
                arb_go_s = pick_vld_s;
            end
            default: begin
                arb_go_s = 1'b0;
            end
        endcase
    end

    // Scheduler state machine; the grant is loaded on entry to ARB so it is visible there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= LAST_CH;
            cur_ch_r     <= {CH_W{1'b0}};
            active_r     <= {NCH{1'b0}};
            ack_cnt_r    <= {WORDS_W{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                remaining_r[i] <= {LEN_W{1'b0}};
            end
            ch_grant_r   <= {NCH{1'b0}};
            ch_done_r    <= {NCH{1'b0}};
            dma_start_r  <= 1'b0;
            dma_ch_r     <= {CH_W{1'b0}};
            dma_words_r  <= {WORDS_W{1'b0}};
            dma_abort_r  <= 1'b0;
        end else begin
            ch_done_r   <= {NCH{1'b0}};
            dma_start_r <= 1'b0;
            dma_abort_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= pick_vld_s ? ARB : IDLE;
                end
                ARB: begin
                    if (dma_words_r == {WORDS_W{1'b0}}) begin
                        state_r              <= RETIRE;
                        ch_done_r[cur_ch_r]  <= 1'b1;
                        active_r[cur_ch_r]   <= 1'b0;
                        last_grant_r         <= cur_ch_r;
                    end else begin
                        state_r     <= ISSUE;
                        dma_start_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_r   <= RUN;
                    ack_cnt_r <= {WORDS_W{1'b0}};
                end
                RUN: begin
                    if (slice_end_s) begin
                        state_r               <= RETIRE;
                        remaining_r[cur_ch_r] <= rem_after_s;
                        last_grant_r          <= cur_ch_r;
                        if (rem_after_s == {LEN_W{1'b0}}) begin
                            ch_done_r[cur_ch_r] <= 1'b1;
                            active_r[cur_ch_r]  <= 1'b0;
                        end
                    end else if (abort_s) begin
                        state_r               <= pick_vld_s ? ARB : IDLE;
                        dma_abort_r           <= 1'b1;
                        active_r[cur_ch_r]    <= 1'b0;
                        remaining_r[cur_ch_r] <= {LEN_W{1'b0}};
                        ch_grant_r            <= {NCH{1'b0}};
                    end else if (bus.dma_word_ack) begin
                        ack_cnt_r <= ack_cnt_r + WORDS_W'(1);
                    end
                end
                RETIRE: begin
                    state_r    <= pick_vld_s ? ARB : IDLE;
                    ch_grant_r <= {NCH{1'b0}};
                end
                default: begin
                    state_r    <= IDLE;
                    ch_grant_r <= {NCH{1'b0}};
                end
            endcase
            if (arb_go_s) begin
                cur_ch_r    <= pick_s;
                dma_ch_r    <= pick_s;
                ch_grant_r  <= ONE_HOT0 << pick_s;
                dma_words_r <= pick_words_s;
                if (!active_r[pick_s]) begin
                    remaining_r[pick_s] <= pick_len_s;
                    active_r[pick_s]    <= 1'b1;
                end
            end
        end
    end

    assign bus.ch_grant  = ch_grant_r;
    assign bus.ch_done   = ch_done_r;
    assign bus.dma_start = dma_start_r;
    assign bus.dma_ch    = dma_ch_r;
    assign bus.dma_words = dma_words_r;
    assign bus.dma_abort = dma_abort_r;
endmodule
